branch_predictor_v2: RTL and testbench

Parametrised dynamic branch predictor for the fetch stage. It generalises the single-scheme, 7-bit bimodal predictor in four ways:
- selectable indexing scheme (bimodal, global, gselect, gshare);
- configurable table depth, history length and counter width;
- speculative global history with repair on mispredict;
- a table-initialisation sequencer and mispredict statistics.

It sits between instruction fetch (predict port) and the ALU stage (resolve port), and drives the pipeline flush.

---
 rtl/branch_predictor_v2_pkg.sv | 28 ++
 rtl/branch_predictor_v2_if.sv | 37 +++
 rtl/branch_predictor_v2_table.sv | 56 +++++
 rtl/branch_predictor_v2.sv | 91 +++++++++
 tb/tb_branch_predictor_v2.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_v2_pkg.sv
// bp_pkg: shared constants, FSM state type and index/counter helpers for branch_predictor_v2
package bp_pkg;
   localparam logic [1:0] SCHEME_BIMODAL = 2'b00;
   localparam logic [1:0] SCHEME_GLOBAL  = 2'b01;
   localparam logic [1:0] SCHEME_GSELECT = 2'b10;
   localparam logic [1:0] SCHEME_GSHARE  = 2'b11;

   typedef enum logic {INIT, RUN} bp_state_e;

   // Helpers work on 32-bit values; callers zero-extend arguments and size-cast the result.
   function automatic logic [31:0] bp_index(input logic [31:0] p, input logic [31:0] g,
                                            input logic [1:0] scheme, input int index_bits,
                                            input int hist_bits);
      logic [31:0] lo_mask;
      lo_mask = (32'd1 << (index_bits - hist_bits)) - 32'd1;
      return scheme == SCHEME_BIMODAL ? p :
             scheme == SCHEME_GLOBAL  ? g :
             scheme == SCHEME_GSELECT ? (g << (index_bits - hist_bits)) | (p & lo_mask) :
                                        p ^ g;
   endfunction

   function automatic logic [31:0] sat_update(input logic [31:0] ctr, input logic taken,
                                              input int ctr_bits);
      logic [31:0] max;
      max = (32'd1 << ctr_bits) - 32'd1;
      return taken ? (ctr == max ? ctr : ctr + 32'd1) : (ctr == 32'd0 ? ctr : ctr - 32'd1);
   endfunction
endpackage

// File: rtl/branch_predictor_v2_if.sv
// branch_predictor_v2_if: fetch predict port, ALU resolve port and predictor outputs.
//   master: fetch/ALU side (drives i_*, reads o_*); slave: the predictor.
interface branch_predictor_v2_if #(
   parameter int ADDRESS_WIDTH = 22,
   parameter int INDEX_BITS    = 7,
   parameter int HIST_BITS     = 4,
   parameter int STAT_BITS     = 16
);
   logic [ADDRESS_WIDTH-1:0] i_IMEM_address;
   logic                     i_IMEM_isbranch;
   logic                     i_ALU_isbranch;
   logic                     i_ALU_outcome;
   logic                     i_ALU_prediction;
   logic [INDEX_BITS-1:0]    i_ALU_index;
   logic [HIST_BITS-1:0]     i_ALU_ghr;
   logic                     o_ready;
   logic                     o_taken;
   logic                     o_valid;
   logic [INDEX_BITS-1:0]    o_index;
   logic [HIST_BITS-1:0]     o_ghr;
   logic                     o_flush;
   logic [STAT_BITS-1:0]     o_branch_count;
   logic [STAT_BITS-1:0]     o_mispredict_count;

   modport master (
      output i_IMEM_address, i_IMEM_isbranch, i_ALU_isbranch, i_ALU_outcome,
             i_ALU_prediction, i_ALU_index, i_ALU_ghr,
      input  o_ready, o_taken, o_valid, o_index, o_ghr, o_flush, o_branch_count,
             o_mispredict_count
   );
   modport slave (
      input  i_IMEM_address, i_IMEM_isbranch, i_ALU_isbranch, i_ALU_outcome,
             i_ALU_prediction, i_ALU_index, i_ALU_ghr,
      output o_ready, o_taken, o_valid, o_index, o_ghr, o_flush, o_branch_count,
             o_mispredict_count
   );
endinterface

// File: rtl/branch_predictor_v2_table.sv
// bp_counter_table: 2^INDEX_BITS saturating counters with init walker.
//   i_rd_index/o_rd_ctr: combinational read (returns pre-write value on a same-cycle write)
//   i_wr_en/i_wr_index/i_wr_taken: saturating update; o_ready: walk finished
module bp_counter_table
   import bp_pkg::*;
#(
   parameter int INDEX_BITS = 7,
   parameter int CTR_BITS   = 2
) (
   input  logic                  i_Clk,
   input  logic                  i_Reset_n,
   input  logic [INDEX_BITS-1:0] i_rd_index,
   output logic [CTR_BITS-1:0]   o_rd_ctr,
   input  logic                  i_wr_en,
   input  logic [INDEX_BITS-1:0] i_wr_index,
   input  logic                  i_wr_taken,
   output logic                  o_ready
);
   localparam int DEPTH = 1 << INDEX_BITS;
   localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

   logic [CTR_BITS-1:0]   mem_q [DEPTH];
   bp_state_e             state_q, state_d;
   logic [INDEX_BITS-1:0] ptr_q, ptr_d;
   logic                  we;
   logic [INDEX_BITS-1:0] wa;
   logic [CTR_BITS-1:0]   wd;

   // The walker owns the write port during INIT; resolves take it in RUN.
   always_comb begin
      state_d = (state_q == INIT && &ptr_q) ? RUN : state_q;
      ptr_d   = state_q == INIT ? ptr_q + INDEX_BITS'(1) : ptr_q;
      we      = state_q == INIT || i_wr_en;
      wa      = state_q == INIT ? ptr_q : i_wr_index;
      wd      = state_q == INIT ? WEAK_NT :
                CTR_BITS'(sat_update(32'(mem_q[i_wr_index]), i_wr_taken, CTR_BITS));
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q <= INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Storage is not reset; the walker rewrites every entry after each reset.
   always_ff @(posedge i_Clk) begin
      if (we) mem_q[wa] <= wd;
   end

   assign o_rd_ctr = mem_q[i_rd_index];
   assign o_ready  = state_q == RUN;
endmodule

// File: rtl/branch_predictor_v2.sv
// branch_predictor_v2: dynamic branch predictor with selectable indexing scheme.
//   i_Clk, i_Reset_n (async, active-low); bp: predict/resolve requests in, registered
//   prediction, flush pulse, ready and saturating statistics out.
module branch_predictor_v2
   import bp_pkg::*;
#(
   parameter int         ADDRESS_WIDTH = 22,
   parameter int         INDEX_BITS    = 7,
   parameter int         HIST_BITS     = 4,
   parameter int         CTR_BITS      = 2,
   parameter logic [1:0] SCHEME        = SCHEME_GSHARE,
   parameter int         STAT_BITS     = 16
) (
   input logic                  i_Clk,
   input logic                  i_Reset_n,
   branch_predictor_v2_if.slave bp
);
   logic [ADDRESS_WIDTH-1:0] addr;
   logic                     ready;
   logic [CTR_BITS-1:0]      rd_ctr;
   logic [INDEX_BITS-1:0]    idx;
   logic                     resolve, mis, predict, taken;
   logic [HIST_BITS-1:0]     ghr_q, ghr_d, ghr_out_q, ghr_out_d;
   logic                     valid_q, valid_d, taken_q, taken_d, flush_q, flush_d;
   logic [INDEX_BITS-1:0]    index_q, index_d;
   logic [STAT_BITS-1:0]     bcnt_q, bcnt_d, mcnt_q, mcnt_d;

   assign addr = bp.i_IMEM_address;
   assign idx  = INDEX_BITS'(bp_index(32'(addr[INDEX_BITS-1:0]), 32'(ghr_q), SCHEME,
                                      INDEX_BITS, HIST_BITS));

   bp_counter_table #(.INDEX_BITS(INDEX_BITS), .CTR_BITS(CTR_BITS)) u_table (
      .i_Clk      (i_Clk),
      .i_Reset_n  (i_Reset_n),
      .i_rd_index (idx),
      .o_rd_ctr   (rd_ctr),
      .i_wr_en    (resolve),
      .i_wr_index (bp.i_ALU_index),
      .i_wr_taken (bp.i_ALU_outcome),
      .o_ready    (ready)
   );

   // A mispredict makes any same-cycle predict wrong-path, so it is dropped and
   // the repaired history wins over the speculative shift.
   always_comb begin
      resolve   = ready & bp.i_ALU_isbranch;
      mis       = resolve & (bp.i_ALU_outcome ^ bp.i_ALU_prediction);
      predict   = ready & bp.i_IMEM_isbranch & ~mis;
      taken     = rd_ctr[CTR_BITS-1];
      ghr_d     = mis ? HIST_BITS'({bp.i_ALU_ghr, bp.i_ALU_outcome}) :
                  predict ? HIST_BITS'({ghr_q, taken}) : ghr_q;
      valid_d   = predict;
      taken_d   = predict ? taken : taken_q;
      index_d   = predict ? idx : index_q;
      ghr_out_d = predict ? ghr_q : ghr_out_q;
      flush_d   = mis;
      bcnt_d    = (resolve && !(&bcnt_q)) ? bcnt_q + STAT_BITS'(1) : bcnt_q;
      mcnt_d    = (mis && !(&mcnt_q)) ? mcnt_q + STAT_BITS'(1) : mcnt_q;
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         ghr_q     <= '0;
         ghr_out_q <= '0;
         valid_q   <= 1'b0;
         taken_q   <= 1'b0;
         index_q   <= '0;
         flush_q   <= 1'b0;
         bcnt_q    <= '0;
         mcnt_q    <= '0;
      end else begin
         ghr_q     <= ghr_d;
         ghr_out_q <= ghr_out_d;
         valid_q   <= valid_d;
         taken_q   <= taken_d;
         index_q   <= index_d;
         flush_q   <= flush_d;
         bcnt_q    <= bcnt_d;
         mcnt_q    <= mcnt_d;
      end
   end

   assign bp.o_ready            = ready;
   assign bp.o_valid            = valid_q;
   assign bp.o_taken            = taken_q;
   assign bp.o_index            = index_q;
   assign bp.o_ghr              = ghr_out_q;
   assign bp.o_flush            = flush_q;
   assign bp.o_branch_count     = bcnt_q;
   assign bp.o_mispredict_count = mcnt_q;
endmodule

// File: tb/tb_branch_predictor_v2.sv
// tb_branch_predictor_v2: scoreboard bench for gshare (default), bimodal and gselect builds
module tb_branch_predictor_v2;
   logic i_Clk = 1'b0;
   logic i_Reset_n = 1'b0;
   always #5 i_Clk = ~i_Clk;

   logic       pb, rb, ro, rp;
   logic [6:0] pa, ri;
   logic [3:0] rg;

   branch_predictor_v2_if #(.ADDRESS_WIDTH(22), .INDEX_BITS(7), .HIST_BITS(4), .STAT_BITS(16)) bif ();
   branch_predictor_v2_if #(.ADDRESS_WIDTH(22), .INDEX_BITS(7), .HIST_BITS(4), .STAT_BITS(4)) bif_b ();
   branch_predictor_v2_if #(.ADDRESS_WIDTH(22), .INDEX_BITS(7), .HIST_BITS(3), .STAT_BITS(16)) bif_g ();

   assign bif.i_IMEM_address   = 22'(pa);
   assign bif.i_IMEM_isbranch  = pb;
   assign bif.i_ALU_isbranch   = rb;
   assign bif.i_ALU_outcome    = ro;
   assign bif.i_ALU_prediction = rp;
   assign bif.i_ALU_index      = ri;
   assign bif.i_ALU_ghr        = rg;
   assign bif_b.i_IMEM_address   = 22'(pa);
   assign bif_b.i_IMEM_isbranch  = pb;
   assign bif_b.i_ALU_isbranch   = rb;
   assign bif_b.i_ALU_outcome    = ro;
   assign bif_b.i_ALU_prediction = rp;
   assign bif_b.i_ALU_index      = ri;
   assign bif_b.i_ALU_ghr        = rg;
   assign bif_g.i_IMEM_address   = 22'(pa);
   assign bif_g.i_IMEM_isbranch  = pb;
   assign bif_g.i_ALU_isbranch   = rb;
   assign bif_g.i_ALU_outcome    = ro;
   assign bif_g.i_ALU_prediction = rp;
   assign bif_g.i_ALU_index      = ri;
   assign bif_g.i_ALU_ghr        = rg[2:0];

   branch_predictor_v2 dut (.i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .bp(bif));
   branch_predictor_v2 #(.SCHEME(2'b00), .STAT_BITS(4)) dut_b (.i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .bp(bif_b));
   branch_predictor_v2 #(.HIST_BITS(3), .SCHEME(2'b10)) dut_g (.i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .bp(bif_g));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model of the default (gshare, 4-bit history, 2-bit counters) build.
   typedef struct {
      logic       v;
      logic       t;
      logic [6:0] i;
      logic [3:0] g;
      logic       f;
   } exp_t;
   exp_t       sb[$];
   int         tbl[128];
   logic [3:0] ghr_m;
   int         init_m, bc_m, mc_m;

   task automatic model_reset();
      for (int i = 0; i < 128; i++) tbl[i] = 1;
      ghr_m  = '0;
      init_m = 0;
      bc_m   = 0;
      mc_m   = 0;
   endtask

   task automatic cyc(input logic b, input logic [6:0] a, input logic r, input logic o,
                      input logic p, input logic [6:0] ix, input logic [3:0] g);
      exp_t e;
      logic rdy, mis, prd;
      logic [6:0] id;
      pb = b; pa = a; rb = r; ro = o; rp = p; ri = ix; rg = g;
      rdy = init_m >= 128;
      mis = rdy && r && (o != p);
      prd = rdy && b && !mis;
      id  = a ^ {3'd0, ghr_m};
      e.v = prd;
      e.t = tbl[id] >= 2;
      e.i = id;
      e.g = ghr_m;
      e.f = mis;
      sb.push_back(e);
      if (rdy && r) begin
         tbl[ix] = o ? (tbl[ix] == 3 ? 3 : tbl[ix] + 1) : (tbl[ix] == 0 ? 0 : tbl[ix] - 1);
         if (bc_m < 65535) bc_m++;
      end
      if (mis) begin
         if (mc_m < 65535) mc_m++;
         ghr_m = {g[2:0], o};
      end else if (prd) ghr_m = {ghr_m[2:0], e.t};
      init_m++;
      @(posedge i_Clk);
      #1;
      e = sb.pop_front();
      check("valid", 32'(bif.o_valid), 32'(e.v));
      if (e.v) begin
         check("taken", 32'(bif.o_taken), 32'(e.t));
         check("index", 32'(bif.o_index), 32'(e.i));
         check("ghr", 32'(bif.o_ghr), 32'(e.g));
      end
      check("flush", 32'(bif.o_flush), 32'(e.f));
      check("ready", 32'(bif.o_ready), 32'(init_m >= 128));
      check("bcount", 32'(bif.o_branch_count), 32'(bc_m));
      check("mcount", 32'(bif.o_mispredict_count), 32'(mc_m));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ready"}, 32'(bif.o_ready), 0);
      check({tag, "_valid"}, 32'(bif.o_valid), 0);
      check({tag, "_taken"}, 32'(bif.o_taken), 0);
      check({tag, "_index"}, 32'(bif.o_index), 0);
      check({tag, "_ghr"}, 32'(bif.o_ghr), 0);
      check({tag, "_flush"}, 32'(bif.o_flush), 0);
      check({tag, "_bcount"}, 32'(bif.o_branch_count), 0);
      check({tag, "_mcount"}, 32'(bif.o_mispredict_count), 0);
   endtask

   initial begin
      pb = 0; pa = '0; rb = 0; ro = 0; rp = 0; ri = '0; rg = '0;
      model_reset();
      repeat (2) @(posedge i_Clk);
      #1;
      check_zero("rst");
      @(negedge i_Clk);
      i_Reset_n = 1'b1;
      // requests during the walk must be ignored
      for (int i = 0; i < 128; i++) cyc(1'b1, 7'(i), 1'b1, 1'b1, 1'b0, 7'(i), 4'h0);
      check("b_ready", 32'(bif_b.o_ready), 1);
      // every entry starts weakly not-taken
      for (int i = 0; i < 128; i++) begin
         cyc(1'b1, 7'(i), 1'b0, 1'b0, 1'b0, 7'd0, 4'h0);
         check("b_init_taken", 32'(bif_b.o_taken), 0);
         check("b_init_index", 32'(bif_b.o_index), 32'(i));
      end
      // bimodal training on address 5
      repeat (2) cyc(1'b0, 7'd0, 1'b1, 1'b1, 1'b1, 7'd5, 4'h0);
      cyc(1'b1, 7'd5, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0);
      check("b_t2", 32'(bif_b.o_taken), 1);
      cyc(1'b0, 7'd0, 1'b1, 1'b1, 1'b1, 7'd5, 4'h0);
      cyc(1'b1, 7'd5, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0);
      check("b_t3", 32'(bif_b.o_taken), 1);
      cyc(1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 7'd5, 4'h0);
      cyc(1'b1, 7'd5, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0);
      check("b_nt1", 32'(bif_b.o_taken), 1);
      cyc(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd5, 4'h0);
      cyc(1'b1, 7'd5, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0);
      check("b_nt2", 32'(bif_b.o_taken), 0);
      // floor saturation: 01 -> 00 and no wrap
      repeat (3) cyc(1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 7'd5, 4'h0);
      cyc(1'b0, 7'd0, 1'b1, 1'b1, 1'b1, 7'd5, 4'h0);
      cyc(1'b1, 7'd5, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0);
      check("b_floor", 32'(bif_b.o_taken), 0);
      cyc(1'b0, 7'd0, 1'b1, 1'b1, 1'b1, 7'd5, 4'h0);
      cyc(1'b1, 7'd5, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0);
      check("b_floor_up", 32'(bif_b.o_taken), 1);
      // gselect (3-bit history) index
      cyc(1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 7'd100, 4'b0010);
      cyc(1'b1, 7'h0F, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0);
      check("gsel_index", 32'(bif_g.o_index), 32'h5F);
      check("gsel_ghr", 32'(bif_g.o_ghr), 32'h5);
      // gshare index
      cyc(1'b0, 7'd0, 1'b1, 1'b0, 1'b1, 7'd100, 4'b0101);
      cyc(1'b1, 7'h0F, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0);
      check("gsh_index", 32'(bif.o_index), 32'h05);
      check("gsh_ghr", 32'(bif.o_ghr), 32'hA);
      // mispredict repair with a wrong-path predict in the same cycle
      cyc(1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 7'd100, 4'b0001);
      cyc(1'b1, 7'd6, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0);
      check("rep_taken", 32'(bif.o_taken), 1);
      check("rep_ghr", 32'(bif.o_ghr), 32'h3);
      cyc(1'b1, 7'd0, 1'b1, 1'b0, 1'b1, 7'd5, 4'b0011);
      check("rep_flush", 32'(bif.o_flush), 1);
      check("rep_drop", 32'(bif.o_valid), 0);
      cyc(1'b1, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0);
      check("rep_flush_end", 32'(bif.o_flush), 0);
      check("rep_ghr_fixed", 32'(bif.o_ghr), 32'h6);
      // statistics saturation on the 4-bit build
      repeat (20) cyc(1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 7'd9, 4'h0);
      check("b_mcount_sat", 32'(bif_b.o_mispredict_count), 32'hF);
      check("b_bcount_sat", 32'(bif_b.o_branch_count), 32'hF);
      // asynchronous reset between edges
      cyc(1'b1, 7'd3, 1'b1, 1'b1, 1'b1, 7'd9, 4'h0);
      #2;
      i_Reset_n = 1'b0;
      #1;
      check_zero("mid_rst");
      sb.delete();
      model_reset();
      @(posedge i_Clk);
      @(negedge i_Clk);
      i_Reset_n = 1'b1;
      for (int i = 0; i < 128; i++) cyc(1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0);
      cyc(1'b1, 7'd5, 1'b0, 1'b0, 1'b0, 7'd0, 4'h0);
      check("erased", 32'(bif_b.o_taken), 0);
      check("erased_valid", 32'(bif_b.o_valid), 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
